imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/mips_pkg.sv | 31 +++
 rtl/imem_byte_serializer.sv | 64 ++++++
 rtl/imem_loader.sv | 147 ++++++++++++++
 tb/tb_imem_loader.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader, the instruction
// memory and the testbench.
//   MEM_BYTES_DEF : default size in bytes of the byte-addressed instruction memory
//   ld_state_e    : loader FSM state encoding
//   be_byte       : selects byte idx of a word, MSB first (big-endian order)
package mips_pkg;

  localparam int MEM_BYTES_DEF = 64;

  typedef enum logic [2:0] {
    LD_IDLE   = 3'd0,
    LD_ACCEPT = 3'd1,
    LD_WRITE  = 3'd2,
    LD_DONE   = 3'd3,
    LD_ERROR  = 3'd4
  } ld_state_e;

  // Index 0 is the most significant byte so memory order matches the
  // big-endian instruction fetch.
  function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/imem_byte_serializer.sv
// Holds one accepted instruction word and presents it one byte per cycle,
// most significant byte first.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (byte index only)
//   load_i    : capture word_i/last_i and restart at byte index 0
//   word_i    : instruction word to serialise
//   last_i    : final-word flag travelling with the word
//   step_i    : advance to the next byte (wraps 3 -> 0)
//   idx_o     : current byte index
//   byte_o    : byte selected by idx_o
//   final_o   : current byte is the last of the word (index 3)
//   last_o    : latched final-word flag
module imem_byte_serializer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic        last_i,
  input  logic        step_i,
  output logic [1:0]  idx_o,
  output logic [7:0]  byte_o,
  output logic        final_o,
  output logic        last_o
);

  logic [31:0] word_q;
  logic        last_q;
  logic [1:0]  idx_q;
  logic [1:0]  idx_d;

  always_comb begin
    idx_d = idx_q;
    if (load_i) begin
      idx_d = 2'd0;
    end else if (step_i) begin
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= 2'd0;
    end else begin
      idx_q <= idx_d;
    end
  end

  // The word is sampled only on load, so later activity on the producer's
  // data bus cannot disturb the bytes being written.
  always_ff @(posedge clk) begin
    if (load_i) begin
      word_q <= word_i;
      last_q <= last_i;
    end
  end

  assign idx_o   = idx_q;
  assign byte_o  = be_byte(word_q, idx_q);
  assign final_o = (idx_q == 2'd3);
  assign last_o  = last_q;

endmodule

// File: rtl/imem_loader.sv
// Streams 32-bit instruction words from a valid/ready producer into a
// byte-addressed instruction memory, one byte per cycle, MSB first, while
// holding the CPU frozen until the whole program is written.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : begin a load session at byte address 0
//   word_valid/word_data/word_last/word_ready : producer handshake
//   mem_we/mem_addr/mem_wd : byte write port to instruction memory
//   cpu_hold            : freezes PC and register-file writes while high
//   done                : program fully written
//   err                 : overflow flag, held until the next start
//   words_loaded        : words written in the current session
module imem_loader
  import mips_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          word_valid,
  input  logic [31:0]                   word_data,
  input  logic                          word_last,
  output logic                          word_ready,
  output logic                          mem_we,
  output logic [31:0]                   mem_addr,
  output logic [7:0]                    mem_wd,
  output logic                          cpu_hold,
  output logic                          done,
  output logic                          err,
  output logic [$clog2(MEM_BYTES/4):0]  words_loaded
);

  localparam int CNT_W = $clog2(MEM_BYTES/4) + 1;

  ld_state_e   state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        ser_load;
  logic        ser_step;
  logic [1:0]  ser_idx;
  logic [7:0]  ser_byte;
  logic        ser_final;
  logic        ser_last;
  logic        overflow;

  imem_byte_serializer u_ser (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ser_load),
    .word_i  (word_data),
    .last_i  (word_last),
    .step_i  (ser_step),
    .idx_o   (ser_idx),
    .byte_o  (ser_byte),
    .final_o (ser_final),
    .last_o  (ser_last)
  );

  // A word that would not fit entirely below MEM_BYTES is consumed but
  // never written.
  assign overflow = (base_q + 32'd4) > 32'(MEM_BYTES);

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    ser_load   = 1'b0;
    ser_step   = 1'b0;
    word_ready = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'd0;
    mem_wd     = 8'd0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    err        = 1'b0;

    case (state_q)
      LD_IDLE: begin
        if (start) begin
          state_d = LD_ACCEPT;
          base_d  = 32'd0;
          cnt_d   = '0;
        end
      end

      LD_ACCEPT: begin
        word_ready = 1'b1;
        if (word_valid) begin
          ser_load = 1'b1;
          state_d  = overflow ? LD_ERROR : LD_WRITE;
        end
      end

      LD_WRITE: begin
        mem_we   = 1'b1;
        mem_addr = base_q + {30'd0, ser_idx};
        mem_wd   = ser_byte;
        ser_step = 1'b1;
        if (ser_final) begin
          base_d  = base_q + 32'd4;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ser_last ? LD_DONE : LD_ACCEPT;
        end
      end

      LD_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (start) begin
          state_d = LD_ACCEPT;
          base_d  = 32'd0;
          cnt_d   = '0;
        end
      end

      LD_ERROR: begin
        err = 1'b1;
        if (start) begin
          state_d = LD_ACCEPT;
          base_d  = 32'd0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = LD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LD_IDLE;
      base_q  <= 32'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
    end
  end

  assign words_loaded = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: reset, directed sessions, overflow,
// mid-write reset, restart behaviour and randomized program loads compared
// against a byte-level model of the expected memory image.
module tb_imem_loader;
  import mips_pkg::*;

  localparam int MB = MEM_BYTES_DEF;

  logic clk = 1'b0;
  logic rst, start, word_valid, word_last;
  logic [31:0] word_data;
  logic word_ready, mem_we, cpu_hold, done, err;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wd;
  logic [$clog2(MB/4):0] words_loaded;

  imem_loader #(.MEM_BYTES(MB)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .word_valid   (word_valid),
    .word_data    (word_data),
    .word_last    (word_last),
    .word_ready   (word_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wd       (mem_wd),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0]  tbmem [MB];
  logic [31:0] wlog_a [$];
  logic [7:0]  wlog_d [$];

  typedef struct {
    logic [31:0] word;
    logic        last;
    int          exp_loaded;
  } vec_t;

  vec_t prog [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: capture the write port before the edge (it models the
  // instruction memory), then step past the edge.
  task automatic tick();
    logic        we;
    logic [31:0] a;
    logic [7:0]  d;
    we = mem_we;
    a  = mem_addr;
    d  = mem_wd;
    if (we === 1'b0) chk("quiet_bus", {31'd0, (a != 32'd0 || d != 8'd0)}, 32'd0);
    @(posedge clk);
    if (we === 1'b1) begin
      if (a < MB) tbmem[int'(a)] = d;
      wlog_a.push_back(a);
      wlog_d.push_back(d);
    end
    #1;
    cyc++;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < MB; i++) tbmem[i] = 8'hEE;
    wlog_a.delete();
    wlog_d.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [31:0] rd32(input int a);
    return {tbmem[a], tbmem[a+1], tbmem[a+2], tbmem[a+3]};
  endfunction

  // Present one word after 'gap' idle cycles, wait for acceptance, then
  // count cycles until the loader is ready again (or done/err).
  task automatic send_word(input logic [31:0] w, input logic last, input int gap,
                           input bit scramble, input bit poke_start, output int post);
    int budget;
    word_valid = 1'b0;
    repeat (gap) tick();
    word_data  = w;
    word_last  = last;
    word_valid = 1'b1;
    budget = 0;
    while (!word_ready && budget < 50) begin
      tick();
      budget++;
    end
    if (!word_ready) chk("ready_timeout", {31'd0, word_ready}, 32'd1);
    tick();
    word_valid = 1'b0;
    word_last  = 1'b0;
    post = 0;
    while (!(word_ready || done || err) && post < 20) begin
      if (scramble) word_data = $urandom;
      start = poke_start && (post == 1);
      tick();
      post++;
    end
    start = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, word_ready}, 32'd0);
    chk({tag, "_we"},    {31'd0, mem_we},     32'd0);
    chk({tag, "_addr"},  mem_addr,            32'd0);
    chk({tag, "_wd"},    {24'd0, mem_wd},     32'd0);
    chk({tag, "_hold"},  {31'd0, cpu_hold},   32'd1);
    chk({tag, "_done"},  {31'd0, done},       32'd0);
    chk({tag, "_err"},   {31'd0, err},        32'd0);
    chk({tag, "_wl"},    32'(words_loaded),   32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int post;
    int bad;
    logic [31:0] ws [17];
    logic [31:0] ea [$];
    logic [7:0]  ed [$];

    prog[0]  = '{32'h20010005, 1'b0, 1};
    prog[1]  = '{32'h2002000C, 1'b0, 2};
    prog[2]  = '{32'hAC010000, 1'b0, 3};
    prog[3]  = '{32'hAC020004, 1'b0, 4};
    prog[4]  = '{32'h8C030000, 1'b0, 5};
    prog[5]  = '{32'h8C040004, 1'b0, 6};
    prog[6]  = '{32'h00641820, 1'b0, 7};
    prog[7]  = '{32'h00221020, 1'b0, 8};
    prog[8]  = '{32'h10220002, 1'b0, 9};
    prog[9]  = '{32'h20050001, 1'b0, 10};
    prog[10] = '{32'h1000FFFF, 1'b1, 11};

    rst = 1'b1; start = 1'b1; word_valid = 1'b0; word_data = 32'd0; word_last = 1'b0;
    clear_mem();

    // Reset with start in the same cycles: reset wins.
    tick();
    tick();
    chk_reset_outputs("rst");
    rst = 1'b0;
    start = 1'b0;
    tick();
    chk("rst_start_ignored", {31'd0, word_ready}, 32'd0);

    // Single word, last.
    clear_mem();
    pulse_start();
    chk("t034_accept_ready", {31'd0, word_ready}, 32'd1);
    send_word(32'h2001000A, 1'b1, 0, 1'b0, 1'b0, post);
    chk("t034_latency", 32'(post), 32'd4);
    chk("t034_nwrites", 32'(wlog_a.size()), 32'd4);
    if (wlog_a.size() == 4) begin
      for (int b = 0; b < 4; b++) begin
        chk("t034_addr", wlog_a[b], 32'(b));
        chk("t034_byte", {24'd0, wlog_d[b]}, 32'h2001000A >> (24 - 8*b) & 32'hFF);
      end
    end
    chk("t034_done", {31'd0, done}, 32'd1);
    chk("t034_hold", {31'd0, cpu_hold}, 32'd0);
    chk("t034_wl", 32'(words_loaded), 32'd1);

    // Start in DONE restarts the session.
    pulse_start();
    chk("t039_done_clr", {31'd0, done}, 32'd0);
    chk("t039_wl_clr", 32'(words_loaded), 32'd0);
    chk("t039_ready", {31'd0, word_ready}, 32'd1);
    chk("t039_hold", {31'd0, cpu_hold}, 32'd1);

    // 11-word program from the table.
    clear_mem();
    for (int i = 0; i < 11; i++) begin
      send_word(prog[i].word, prog[i].last, 0, 1'b0, 1'b0, post);
      chk("t035_loaded", 32'(words_loaded), 32'(prog[i].exp_loaded));
    end
    for (int i = 0; i < 11; i++) chk("t035_readback", rd32(4*i), prog[i].word);
    chk("t035_addr28", rd32(28), 32'h00221020);
    chk("t035_done", {31'd0, done}, 32'd1);
    chk("t035_wl", 32'(words_loaded), 32'd11);

    // Stalls, data changing during WRITE, start during WRITE.
    pulse_start();
    clear_mem();
    send_word(32'h11223344, 1'b0, 0, 1'b0, 1'b0, post);
    chk("t036_spacing", 32'(post + 1), 32'd5);
    send_word(32'hA5B6C7D8, 1'b0, 7, 1'b1, 1'b1, post);
    chk("t036_spacing_stall", 32'(post + 1), 32'd5);
    chk("t036_nwrites", 32'(wlog_a.size()), 32'd8);
    send_word(32'h0F1E2D3C, 1'b1, 0, 1'b1, 1'b0, post);
    chk("t036_w0", rd32(0), 32'h11223344);
    chk("t036_w1", rd32(4), 32'hA5B6C7D8);
    chk("t036_w2", rd32(8), 32'h0F1E2D3C);
    bad = 0;
    for (int i = 0; i < wlog_a.size(); i++) if (wlog_a[i] != 32'(i)) bad++;
    chk("t039_start_in_write_ignored", 32'(bad), 32'd0);
    chk("t036_nwrites_total", 32'(wlog_a.size()), 32'd12);
    chk("t036_wl", 32'(words_loaded), 32'd3);

    // Overflow: 17 words into 64 bytes.
    pulse_start();
    clear_mem();
    for (int i = 0; i < 17; i++) begin
      ws[i] = $urandom;
      send_word(ws[i], 1'b0, 0, 1'b0, 1'b0, post);
      chk("t037_post", 32'(post), (i < 16) ? 32'd4 : 32'd0);
    end
    chk("t037_err", {31'd0, err}, 32'd1);
    chk("t037_hold", {31'd0, cpu_hold}, 32'd1);
    chk("t037_ready", {31'd0, word_ready}, 32'd0);
    chk("t037_wl", 32'(words_loaded), 32'd16);
    chk("t037_nwrites", 32'(wlog_a.size()), 32'd64);
    bad = 0;
    for (int i = 0; i < 16; i++) if (rd32(4*i) != ws[i]) bad++;
    chk("t037_content", 32'(bad), 32'd0);
    tick(); tick(); tick();
    chk("t037_err_sticky", {31'd0, err}, 32'd1);
    chk("t037_no_late_write", 32'(wlog_a.size()), 32'd64);
    pulse_start();
    chk("t037_err_clr", {31'd0, err}, 32'd0);
    chk("t037_restart_ready", {31'd0, word_ready}, 32'd1);
    chk("t037_restart_wl", 32'(words_loaded), 32'd0);
    clear_mem();
    send_word(32'hDEADBEEF, 1'b1, 0, 1'b0, 1'b0, post);
    chk("t037_restart_addr0", rd32(0), 32'hDEADBEEF);

    // Reset on the second byte of word 3.
    pulse_start();
    clear_mem();
    ws[0] = 32'h01020304; ws[1] = 32'h05060708; ws[2] = 32'hC3D4E5F6;
    send_word(ws[0], 1'b0, 0, 1'b0, 1'b0, post);
    send_word(ws[1], 1'b0, 0, 1'b0, 1'b0, post);
    word_data = ws[2]; word_last = 1'b0; word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    tick();
    chk("t038_second_byte_addr", mem_addr, 32'd9);
    chk("t038_second_byte_we", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    tick();
    chk_reset_outputs("t038");
    rst = 1'b0;
    tick(); tick(); tick();
    chk("t038_nwrites", 32'(wlog_a.size()), 32'd10);
    chk("t038_b8", {24'd0, tbmem[8]}, {24'd0, ws[2][31:24]});
    chk("t038_b9", {24'd0, tbmem[9]}, {24'd0, ws[2][23:16]});
    chk("t038_b10_untouched", {24'd0, tbmem[10]}, 32'hEE);
    chk("t038_idle_ready", {31'd0, word_ready}, 32'd0);

    // Randomized sessions against a byte-image model.
    for (int s = 0; s < 5; s++) begin
      int n;
      int nw;
      n  = $urandom_range(1, 17);
      nw = (n > 16) ? 16 : n;
      pulse_start();
      clear_mem();
      ea.delete();
      ed.delete();
      for (int i = 0; i < n; i++) ws[i] = $urandom;
      for (int i = 0; i < nw; i++)
        for (int b = 0; b < 4; b++) begin
          ea.push_back(32'(4*i + b));
          ed.push_back(ws[i][31-8*b -: 8]);
        end
      for (int i = 0; i < n; i++) begin
        send_word(ws[i], (i == n-1), $urandom_range(0, 3), 1'b1, 1'b0, post);
        chk("rnd_post", 32'(post), (i >= 16) ? 32'd0 : 32'd4);
      end
      chk("rnd_nwrites", 32'(wlog_a.size()), 32'(ea.size()));
      bad = 0;
      if (wlog_a.size() == ea.size()) begin
        for (int i = 0; i < ea.size(); i++)
          if (wlog_a[i] != ea[i] || wlog_d[i] != ed[i]) bad++;
      end else begin
        bad = 1;
      end
      chk("rnd_write_stream", 32'(bad), 32'd0);
      chk("rnd_done", {31'd0, done}, {31'd0, (n <= 16)});
      chk("rnd_err", {31'd0, err}, {31'd0, (n > 16)});
      chk("rnd_wl", 32'(words_loaded), 32'(nw));
      chk("rnd_hold", {31'd0, cpu_hold}, {31'd0, (n > 16)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
